mem_port_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer in front of `storage_controller`. It shares that block's single memory port between the scalar core (port 0) and the vector unit (port 1).
- Grants round-robin.
- Holds each command stable until `out_valid`.
- Enforces the idle gap the controller needs between accesses.
- Steers SRAM vs external QSPI by address.
- Rejects unsupported or aborted accesses with an error response.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares storage_controller's single memory port between the
// scalar core (port 0) and the vector unit (port 1). It grants round-robin,
// holds each command until the controller answers, and inserts the controller's
// idle cycle after every access. It steers SRAM vs QSPI by address, and answers
// rejected, timed-out or aborted accesses with an error response.
//
// Handshake: a requester raises req_valid[p] with its command and holds both
// stable until it sees req_ready[p] high for one cycle. That cycle is the
// accept. The requester may drop or change its command from the next cycle.
// Each accepted command receives exactly one resp_valid[p] pulse, with
// resp_err[p] and the shared resp_rdata qualified by that pulse.
module mem_port_arbiter #(
    parameter logic [31:0] SRAM_TOP = 32'h0000_0FFF,
    parameter int          TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_mode,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    input  logic [1:0][3:0]  req_be,
    output logic [1:0]       resp_valid,
    output logic [1:0]       resp_err,
    output logic [31:0]      resp_rdata,
    output logic             mem_access,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             mem_ext,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rvalid,
    output logic             timeout_flag
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic          last;
    logic          owner;
    logic          drain_pend;
    logic [CW-1:0] cnt;
    logic          win;
    logic          do_grant;

    function automatic logic [1:0] port_bit(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Pick the winner and decide whether a grant is issued this cycle. A grant
    // can be issued while the previous response is on the wire. The winner then
    // sees req_ready in the first IDLE cycle, so SRAM accesses pipeline every
    // 4 cycles.
    always_comb begin
        win = req_valid[1];
        if (req_valid == 2'b11) begin
            win = ~last;
        end
        do_grant = 1'b0;
        if (!prog_mode && (|req_valid)) begin
            if (state == IDLE && !(|req_ready)) begin
                do_grant = 1'b1;
            end
            if (state == RESP && !drain_pend) begin
                do_grant = 1'b1;
            end
        end
    end

    // Sequencer FSM with registered outputs. The command latch is the set of
    // mem_* registers: they are loaded on grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            drain_pend   <= 1'b0;
            cnt          <= '0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_err     <= '0;
            resp_rdata   <= '0;
            mem_access   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            mem_ext      <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            resp_err   <= '0;
            case (state)
                IDLE: begin
                    // The cycle after a grant: issue the access, or refuse it
                    // (external writes unsupported, or programming mode started).
                    if (|req_ready) begin
                        if (prog_mode || (mem_we && mem_ext)) begin
                            state      <= RESP;
                            resp_valid <= port_bit(owner);
                            resp_err   <= port_bit(owner);
                            resp_rdata <= '0;
                        end else begin
                            state      <= BUSY;
                            mem_access <= 1'b1;
                            cnt        <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Priority: programming mode, then controller answer, then timeout.
                    if (prog_mode) begin
                        state      <= RESP;
                        mem_access <= 1'b0;
                        drain_pend <= 1'b0;
                        resp_valid <= port_bit(owner);
                        resp_err   <= port_bit(owner);
                        resp_rdata <= '0;
                    end else if (mem_rvalid) begin
                        state      <= RESP;
                        mem_access <= 1'b0;
                        resp_valid <= port_bit(owner);
                        resp_rdata <= mem_we ? 32'h0 : mem_rdata;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state        <= RESP;
                        mem_access   <= 1'b0;
                        timeout_flag <= 1'b1;
                        drain_pend   <= 1'b1;
                        resp_valid   <= port_bit(owner);
                        resp_err     <= port_bit(owner);
                        resp_rdata   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (drain_pend && !prog_mode) begin
                        state <= DRAIN;
                    end else begin
                        state      <= IDLE;
                        drain_pend <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Swallow the late answer of a timed-out access before reuse.
                    if (prog_mode || mem_rvalid) begin
                        state      <= IDLE;
                        drain_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (do_grant) begin
                req_ready <= port_bit(win);
                owner     <= win;
                last      <= win;
                mem_we    <= req_we[win];
                mem_addr  <= req_addr[win];
                mem_wdata <= req_wdata[win];
                mem_be    <= req_be[win];
                mem_ext   <= (req_addr[win] >= SRAM_TOP);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The main instance uses the default
// TIMEOUT. A second instance with TIMEOUT = 8 covers the timeout path and
// shares the command data inputs.
module tb_mem_port_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             prog_mode = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0][3:0]  req_be = '0;
    logic [31:0]      mem_rdata = '0;
    logic             mem_rvalid = 1'b0;
    logic [1:0]       req_ready, resp_valid, resp_err;
    logic [31:0]      resp_rdata, mem_addr, mem_wdata;
    logic             mem_access, mem_we, mem_ext, timeout_flag;
    logic [3:0]       mem_be;

    logic [1:0]       t_req_valid = '0;
    logic             t_mem_rvalid = 1'b0;
    logic [1:0]       t_req_ready, t_resp_valid, t_resp_err;
    logic [31:0]      t_resp_rdata, t_mem_addr, t_mem_wdata;
    logic             t_mem_access, t_mem_we, t_mem_ext, t_timeout_flag;
    logic [3:0]       t_mem_be;

    int total = 0;
    int bad = 0;
    logic [1:0] exp_q[$];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_access(mem_access), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ext(mem_ext),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .timeout_flag(timeout_flag)
    );

    mem_port_arbiter #(.TIMEOUT(8)) dut_t (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(t_resp_valid), .resp_err(t_resp_err), .resp_rdata(t_resp_rdata),
        .mem_access(t_mem_access), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_be(t_mem_be), .mem_ext(t_mem_ext),
        .mem_rdata(mem_rdata), .mem_rvalid(t_mem_rvalid), .timeout_flag(t_timeout_flag)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        prog_mode = 1'b0;
        req_valid = '0;
        t_req_valid = '0;
        req_we = '0;
        mem_rvalid = 1'b0;
        t_mem_rvalid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_access, mem_we, mem_addr,
             mem_wdata, mem_be, mem_ext, timeout_flag} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b rv=%b mem_access=%b addr=%h want all 0",
                     req_ready, resp_valid, mem_access, mem_addr);
        end
        // reset in the middle of an access, then check round-robin pointer restart
        rst = 1'b1;
        req_valid = 2'b01;
        req_addr[0] = 32'h0000_0040;
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({req_ready, resp_valid, resp_err, mem_access, mem_addr, mem_ext} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got ready=%b rv=%b mem_access=%b addr=%h want all 0",
                     req_ready, resp_valid, mem_access, mem_addr);
        end
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_last: got req_ready=%b want 01", req_ready);
        end
        do_reset();
    endtask

    task automatic test_sram_read;
        do_reset();
        req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0] = 32'h0000_0100;
        tick();
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL sram_ready: got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
        total++;
        if ({mem_access, mem_we, mem_ext, mem_addr} !== {3'b100, 32'h0000_0100}) begin
            bad++;
            $display("FAIL sram_issue: got acc=%b we=%b ext=%b addr=%h want 1 0 0 00000100",
                     mem_access, mem_we, mem_ext, mem_addr);
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        total++;
        if (mem_access !== 1'b1) begin
            bad++;
            $display("FAIL sram_hold: got mem_access=%b want 1", mem_access);
        end
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({resp_valid, resp_err, resp_rdata, mem_access} !== {2'b01, 2'b00, 32'hCAFE_F00D, 1'b0}) begin
            bad++;
            $display("FAIL sram_resp: got rv=%b err=%b rdata=%h acc=%b want 01 00 cafef00d 0",
                     resp_valid, resp_err, resp_rdata, mem_access);
        end
    endtask

    task automatic test_contention;
        int acc_n;
        int last_cyc;
        logic [1:0] cur;
        logic [1:0] want;
        do_reset();
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        req_we = 2'b00;
        req_addr[0] = 32'h0000_0200;
        req_addr[1] = 32'h0000_0300;
        req_valid = 2'b11;
        acc_n = 0;
        last_cyc = -3;
        cur = 2'b00;
        for (int i = 1; i <= 24; i++) begin
            tick();
            acc_n = mem_access ? acc_n + 1 : 0;
            mem_rvalid = (acc_n == 2);
            mem_rdata = 32'h1000_0000 + i;
            if (req_ready !== 2'b00) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b11;
                total++;
                if (req_ready !== want || (i - last_cyc) != 4) begin
                    bad++;
                    $display("FAIL contention_grant: cycle %0d got %b want %b gap %0d want 4",
                             i, req_ready, want, i - last_cyc);
                end
                last_cyc = i;
                cur = req_ready;
            end
            if (resp_valid === 2'b11) begin
                total++;
                bad++;
                $display("FAIL contention_overlap: cycle %0d got resp_valid=11 want one-hot", i);
            end
            if (mem_access && mem_addr !== (cur[1] ? 32'h0000_0300 : 32'h0000_0200)) begin
                total++;
                bad++;
                $display("FAIL contention_addr: cycle %0d got %h for grant %b", i, mem_addr, cur);
            end
        end
        req_valid = 2'b00;
        mem_rvalid = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL contention_count: got %0d grants missing want 0", exp_q.size());
        end
    endtask

    task automatic test_ext_stall;
        int bad_cyc;
        do_reset();
        req_valid = 2'b10;
        req_we = 2'b00;
        req_addr[1] = 32'h0000_2000;
        tick();
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL ext_ready: got %b want 10", req_ready);
        end
        req_valid = 2'b00;
        bad_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!(mem_access === 1'b1 && mem_ext === 1'b1 && mem_addr === 32'h0000_2000 &&
                  resp_valid === 2'b00)) bad_cyc++;
            if (i == 40) begin
                mem_rvalid = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
        end
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL ext_stable: got %0d unstable cycles want 0", bad_cyc);
        end
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 2'b00, 32'h1234_5678}) begin
            bad++;
            $display("FAIL ext_resp: got rv=%b err=%b rdata=%h want 10 00 12345678",
                     resp_valid, resp_err, resp_rdata);
        end
    endtask

    task automatic test_reject_write;
        logic acc_seen;
        do_reset();
        req_valid = 2'b01;
        req_we = 2'b01;
        req_addr[0] = 32'h0000_1000;
        req_wdata[0] = 32'h5555_AAAA;
        req_be[0] = 4'hF;
        tick();
        acc_seen = mem_access;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reject_ready: got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        tick();
        acc_seen = acc_seen | mem_access;
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b01, 2'b01, 32'h0}) begin
            bad++;
            $display("FAIL reject_resp: got rv=%b err=%b rdata=%h want 01 01 0",
                     resp_valid, resp_err, resp_rdata);
        end
        tick();
        acc_seen = acc_seen | mem_access;
        tick();
        acc_seen = acc_seen | mem_access;
        total++;
        if (acc_seen !== 1'b0) begin
            bad++;
            $display("FAIL reject_noaccess: got mem_access seen=%b want 0", acc_seen);
        end
        req_we = 2'b00;
    endtask

    task automatic test_boundary;
        do_reset();
        // 0xFFE is the last SRAM address: write is accepted
        req_valid = 2'b01;
        req_we = 2'b01;
        req_addr[0] = 32'h0000_0FFE;
        req_wdata[0] = 32'hA5A5_5A5A;
        req_be[0] = 4'b0011;
        tick();
        req_valid = 2'b00;
        tick();
        total++;
        if ({mem_access, mem_we, mem_ext, mem_addr, mem_wdata, mem_be} !==
            {3'b110, 32'h0000_0FFE, 32'hA5A5_5A5A, 4'b0011}) begin
            bad++;
            $display("FAIL bound_write: got acc=%b we=%b ext=%b addr=%h wd=%h be=%b",
                     mem_access, mem_we, mem_ext, mem_addr, mem_wdata, mem_be);
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b01, 2'b00, 32'h0}) begin
            bad++;
            $display("FAIL bound_wresp: got rv=%b err=%b rdata=%h want 01 00 0",
                     resp_valid, resp_err, resp_rdata);
        end
        // back-to-back: request during RESP, accepted the very next cycle
        req_valid = 2'b10;
        req_we = 2'b00;
        req_addr[1] = 32'h0000_0FFF;
        tick();
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL bound_b2b_ready: got %b want 10", req_ready);
        end
        req_valid = 2'b00;
        tick();
        total++;
        if ({mem_access, mem_ext, mem_addr} !== {2'b11, 32'h0000_0FFF}) begin
            bad++;
            $display("FAIL bound_ext: got acc=%b ext=%b addr=%h want 1 1 00000fff",
                     mem_access, mem_ext, mem_addr);
        end
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 2'b00, 32'h0BAD_F00D}) begin
            bad++;
            $display("FAIL bound_rresp: got rv=%b err=%b rdata=%h want 10 00 0badf00d",
                     resp_valid, resp_err, resp_rdata);
        end
    endtask

    task automatic test_timeout;
        int bad_cyc;
        do_reset();
        t_req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0] = 32'h0000_0300;
        req_addr[1] = 32'h0000_0400;
        tick();
        total++;
        if (t_req_ready !== 2'b01) begin
            bad++;
            $display("FAIL to_ready: got %b want 01", t_req_ready);
        end
        t_req_valid = 2'b00;
        bad_cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!(t_mem_access === 1'b1 && t_resp_valid === 2'b00)) bad_cyc++;
        end
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL to_busy: got %0d bad busy cycles want 0", bad_cyc);
        end
        tick();
        total++;
        if ({t_resp_valid, t_resp_err, t_resp_rdata, t_timeout_flag, t_mem_access} !==
            {2'b01, 2'b01, 32'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL to_resp: got rv=%b err=%b rdata=%h flag=%b acc=%b want 01 01 0 1 0",
                     t_resp_valid, t_resp_err, t_resp_rdata, t_timeout_flag, t_mem_access);
        end
        t_req_valid = 2'b10;
        bad_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (t_req_ready !== 2'b00 || t_resp_valid !== 2'b00 || t_mem_access !== 1'b0) bad_cyc++;
            if (i == 20) begin
                t_mem_rvalid = 1'b1;
                mem_rdata = 32'hFFFF_0000;
            end
        end
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL to_drain: got %0d cycles with grant/resp/access want 0", bad_cyc);
        end
        tick();
        t_mem_rvalid = 1'b0;
        total++;
        if (t_req_ready !== 2'b00 || t_resp_valid !== 2'b00) begin
            bad++;
            $display("FAIL to_discard: got ready=%b rv=%b want 00 00", t_req_ready, t_resp_valid);
        end
        tick();
        total++;
        if (t_req_ready !== 2'b10) begin
            bad++;
            $display("FAIL to_regrant: got %b want 10", t_req_ready);
        end
        t_req_valid = 2'b00;
        tick();
        t_mem_rvalid = 1'b1;
        mem_rdata = 32'h7777_0001;
        tick();
        t_mem_rvalid = 1'b0;
        total++;
        if ({t_resp_valid, t_resp_err, t_resp_rdata, t_timeout_flag} !==
            {2'b10, 2'b00, 32'h7777_0001, 1'b1}) begin
            bad++;
            $display("FAIL to_after: got rv=%b err=%b rdata=%h flag=%b want 10 00 77770001 1",
                     t_resp_valid, t_resp_err, t_resp_rdata, t_timeout_flag);
        end
        do_reset();
        total++;
        if (t_timeout_flag !== 1'b0) begin
            bad++;
            $display("FAIL to_flag_reset: got %b want 0", t_timeout_flag);
        end
    endtask

    task automatic test_prog_abort;
        int bad_cyc;
        do_reset();
        req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0] = 32'h0000_0500;
        tick();
        req_valid = 2'b00;
        tick();
        prog_mode = 1'b1;
        tick();
        total++;
        if ({resp_valid, resp_err, resp_rdata, mem_access} !== {2'b01, 2'b01, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL prog_resp: got rv=%b err=%b rdata=%h acc=%b want 01 01 0 0",
                     resp_valid, resp_err, resp_rdata, mem_access);
        end
        req_valid = 2'b10;
        req_addr[1] = 32'h0000_0180;
        bad_cyc = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (req_ready !== 2'b00 || mem_access !== 1'b0) bad_cyc++;
        end
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL prog_nogrant: got %0d cycles with grant/access want 0", bad_cyc);
        end
        prog_mode = 1'b0;
        tick();
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL prog_resume_ready: got %b want 10", req_ready);
        end
        req_valid = 2'b00;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5151_A0A0;
        tick();
        mem_rvalid = 1'b0;
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 2'b00, 32'h5151_A0A0}) begin
            bad++;
            $display("FAIL prog_resume_resp: got rv=%b err=%b rdata=%h want 10 00 5151a0a0",
                     resp_valid, resp_err, resp_rdata);
        end
    endtask

    task automatic test_simultaneous;
        // controller answer on the last allowed BUSY cycle beats the timeout
        do_reset();
        t_req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0] = 32'h0000_0600;
        tick();
        t_req_valid = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 8) begin
                t_mem_rvalid = 1'b1;
                mem_rdata = 32'h8888_0008;
            end
        end
        tick();
        t_mem_rvalid = 1'b0;
        total++;
        if ({t_resp_valid, t_resp_err, t_resp_rdata, t_timeout_flag} !==
            {2'b01, 2'b00, 32'h8888_0008, 1'b0}) begin
            bad++;
            $display("FAIL sim_rv_timeout: got rv=%b err=%b rdata=%h flag=%b want 01 00 88880008 0",
                     t_resp_valid, t_resp_err, t_resp_rdata, t_timeout_flag);
        end
        t_req_valid = 2'b10;
        tick();
        total++;
        if (t_req_ready !== 2'b10) begin
            bad++;
            $display("FAIL sim_nodrain: got %b want 10", t_req_ready);
        end
        // programming mode beats a controller answer in the same cycle
        do_reset();
        req_valid = 2'b01;
        req_addr[0] = 32'h0000_0700;
        tick();
        req_valid = 2'b00;
        tick();
        mem_rvalid = 1'b1;
        prog_mode = 1'b1;
        mem_rdata = 32'h9999_9999;
        tick();
        mem_rvalid = 1'b0;
        prog_mode = 1'b0;
        total++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b01, 2'b01, 32'h0}) begin
            bad++;
            $display("FAIL sim_prog_rv: got rv=%b err=%b rdata=%h want 01 01 0",
                     resp_valid, resp_err, resp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_sram_read();
        test_contention();
        test_ext_stall();
        test_reject_write();
        test_boundary();
        test_timeout();
        test_prog_abort();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
